// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM session transaction stage:
//   - one-hot FSM state constants (ST_IDLE .. ST_DONE)
//   - transaction type encodings (TIPO_DEPOSITO / TIPO_RETIRO)
// -----------------------------------------------------------------------------
package atm_pkg;

  localparam int ST_W = 5;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE       = 5'b00001;
  localparam state_t ST_WAIT_TIPO  = 5'b00010;
  localparam state_t ST_WAIT_MONTO = 5'b00100;
  localparam state_t ST_EXEC       = 5'b01000;
  localparam state_t ST_DONE       = 5'b10000;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/atm_transaction_engine_timeout.sv
// -----------------------------------------------------------------------------
// atm_timeout_counter
// Inactivity counter for the session wait states.
// Ports:
//   clk      in  : clock
//   reset    in  : synchronous, active-low reset
//   clr      in  : clear the count (has priority over en)
//   en       in  : count this cycle
//   expirado out : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module atm_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expirado
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expirado = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Hold at the terminal count so the counter never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expirado)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/atm_transaction_engine.sv
// -----------------------------------------------------------------------------
// atm_transaction_engine
// Session transaction stage of the automatic cashier. Opens a session on
// pin_ok, runs deposits/withdrawals against the working balance, and closes
// on terminar or inactivity timeout, strobing fin for balance writeback.
// Ports:
//   clk, reset (sync, active-low)
//   pin_ok, balance_in           : session open + initial balance
//   tipo_stb, tipo               : transaction type (0 deposit, 1 withdrawal)
//   monto_stb, monto             : transaction amount
//   terminar                     : user end-of-session request
//   balance_out                  : registered working balance
//   sesion_activa, fin           : session status / end-of-session pulse
//   deposito_ok, entregar_dinero,
//   fondos_insuficientes,
//   limite_excedido              : one-cycle result pulses
// Configuration macro: WITHDRAW_LIMIT_EN enables the per-session cumulative
// withdrawal cap (LIMITE_RETIRO); without it limite_excedido is tied low.
// -----------------------------------------------------------------------------
module atm_transaction_engine
  import atm_pkg::*;
#(
  parameter int BAL_W          = 32,
  parameter int MONTO_W        = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LIMITE_RETIRO  = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pin_ok,
  input  logic [BAL_W-1:0]   balance_in,
  input  logic               tipo_stb,
  input  logic               tipo,
  input  logic               monto_stb,
  input  logic [MONTO_W-1:0] monto,
  input  logic               terminar,
  output logic [BAL_W-1:0]   balance_out,
  output logic               sesion_activa,
  output logic               deposito_ok,
  output logic               entregar_dinero,
  output logic               fondos_insuficientes,
  output logic               limite_excedido,
  output logic               fin
);

  state_t state_q, state_d;

  logic [BAL_W-1:0]   bal_q, bal_d;
  logic               tipo_q, tipo_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic               dep_q, dep_d, ent_q, ent_d, fnd_q, fnd_d, lim_q, lim_d;
  logic [BAL_W-1:0]   monto_w;
  logic               expirado;

  assign monto_w = BAL_W'(monto_q);

  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0]   a,
                                              input logic [MONTO_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + (BAL_W + 1)'(b);
    return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
  endfunction

`ifdef WITHDRAW_LIMIT_EN
  localparam int ACC_W = MONTO_W + BAL_W;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(monto_q);
`endif

  // Every accepted strobe moves the FSM, so any state change restarts the
  // idle count; the count only runs while waiting for user input.
  atm_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_d != state_q),
    .en       ((state_q == ST_WAIT_TIPO) || (state_q == ST_WAIT_MONTO)),
    .expirado (expirado)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // FSM next state: terminar beats strobes, strobes beat timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (pin_ok) state_d = ST_WAIT_TIPO;
      ST_WAIT_TIPO: begin
        if (terminar)      state_d = ST_DONE;
        else if (tipo_stb) state_d = ST_WAIT_MONTO;
        else if (expirado) state_d = ST_DONE;
      end
      ST_WAIT_MONTO: begin
        if (terminar)       state_d = ST_DONE;
        else if (monto_stb) state_d = ST_EXEC;
        else if (expirado)  state_d = ST_DONE;
      end
      ST_EXEC:       state_d = ST_WAIT_TIPO;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    sesion_activa = (state_q != ST_IDLE);
    fin           = (state_q == ST_DONE);
  end

  // Datapath next state: balance, latches, result pulses
  always_comb begin
    bal_d   = bal_q;
    tipo_d  = tipo_q;
    monto_d = monto_q;
    dep_d   = 1'b0;
    ent_d   = 1'b0;
    fnd_d   = 1'b0;
    lim_d   = 1'b0;
`ifdef WITHDRAW_LIMIT_EN
    acc_d   = acc_q;
`endif
    if (state_q == ST_IDLE && pin_ok) begin
      bal_d = balance_in;
`ifdef WITHDRAW_LIMIT_EN
      acc_d = '0;
`endif
    end
    if (state_q == ST_WAIT_TIPO && tipo_stb)
      tipo_d = tipo;
    if (state_q == ST_WAIT_MONTO && monto_stb)
      monto_d = monto;
    // A zero amount is a no-op for either type.
    if (state_q == ST_EXEC && monto_q != '0) begin
      case (tipo_q)
        TIPO_DEPOSITO: begin
          bal_d = sat_add(bal_q, monto_q);
          dep_d = 1'b1;
        end
        TIPO_RETIRO: begin
          if (monto_w > bal_q)
            fnd_d = 1'b1;
`ifdef WITHDRAW_LIMIT_EN
          else if (acc_sum > (ACC_W + 1)'(LIMITE_RETIRO))
            lim_d = 1'b1;
`endif
          else begin
            bal_d = bal_q - monto_w;
            ent_d = 1'b1;
`ifdef WITHDRAW_LIMIT_EN
            acc_d = acc_q + ACC_W'(monto_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bal_q <= '0;
      dep_q <= 1'b0;
      ent_q <= 1'b0;
      fnd_q <= 1'b0;
      lim_q <= 1'b0;
    end else begin
      bal_q <= bal_d;
      dep_q <= dep_d;
      ent_q <= ent_d;
      fnd_q <= fnd_d;
      lim_q <= lim_d;
    end
  end

  // Type/amount latches carry no state across sessions; no reset needed.
  always_ff @(posedge clk) begin
    tipo_q  <= tipo_d;
    monto_q <= monto_d;
  end

`ifdef WITHDRAW_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end
`endif

  assign balance_out          = bal_q;
  assign deposito_ok          = dep_q;
  assign entregar_dinero      = ent_q;
  assign fondos_insuficientes = fnd_q;
`ifdef WITHDRAW_LIMIT_EN
  assign limite_excedido      = lim_q;
`else
  assign limite_excedido      = 1'b0;
`endif

endmodule

// File: doc/atm_transaction_engine.md
# atm_transaction_engine

Session transaction stage of the automatic cashier, directly downstream of the PIN-entry stage. It opens a session on the PIN-verified pulse and loads the account balance. It then runs any number of deposit or withdrawal requests against that balance. It closes the session on request or on inactivity timeout, and strobes the final balance for writeback.

## Interface
- `BAL_W`, 32: balance width, unsigned.
- `MONTO_W`, 16: amount width, unsigned, `MONTO_W <= BAL_W`.
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed in a wait state before forced session end. Must be ≥ 2.
- `LIMITE_RETIRO`, 50000: per-session cumulative withdrawal cap. Used only with `WITHDRAW_LIMIT_EN`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `pin_ok` in 1: one-cycle pulse from the PIN stage that opens a session.
- `balance_in` in BAL_W: account balance, sampled on `pin_ok`.
- `tipo_stb` in 1: transaction-type strobe.
- `tipo` in 1: 0 = deposit, 1 = withdrawal. Valid with `tipo_stb`.
- `monto_stb` in 1: amount strobe.
- `monto` in MONTO_W: amount. Valid with `monto_stb`.
- `terminar` in 1: user request to end the session.
- `balance_out` out BAL_W: working balance. Registered.
- `sesion_activa` out 1: high from WAIT_TIPO through DONE.
- `deposito_ok` out 1: one-cycle pulse when a deposit is applied.
- `entregar_dinero` out 1: one-cycle pulse when a withdrawal is approved.
- `fondos_insuficientes` out 1: one-cycle pulse when a withdrawal exceeds the balance.
- `limite_excedido` out 1: one-cycle pulse when a withdrawal exceeds the session cap.
- `fin` out 1: one-cycle pulse at session end. `balance_out` is valid for writeback in that cycle.

## Operation
- States, one-hot: IDLE, WAIT_TIPO, WAIT_MONTO, EXEC, DONE.
- IDLE, `pin_ok`=1: load `balance_out` ← `balance_in`, clear the withdrawn accumulator and the timeout counter, go to WAIT_TIPO. `pin_ok` in any other state is ignored.
- WAIT_TIPO, `tipo_stb`: latch `tipo`, go to WAIT_MONTO.
- WAIT_MONTO, `monto_stb`: latch `monto`, go to EXEC. `tipo_stb` in WAIT_MONTO is ignored.
- EXEC lasts one cycle, then returns to WAIT_TIPO. Its register updates are visible in the next cycle:
  - Deposit: `balance_out` ← min(balance + monto, 2^BAL_W−1), saturating. Pulse `deposito_ok`.
  - Withdrawal with monto > balance: balance unchanged, pulse `fondos_insuficientes`.
  - Withdrawal, otherwise: balance − monto, add monto to the accumulator, pulse `entregar_dinero`.
  - monto = 0: no-op for either type. No pulse, balance unchanged.
- `terminar`=1 in WAIT_TIPO or WAIT_MONTO goes to DONE. In WAIT_MONTO the latched type is discarded.
- `terminar` and `monto_stb` together in WAIT_MONTO: `terminar` wins and the amount is discarded.
- `terminar` and `tipo_stb` together in WAIT_TIPO: `terminar` wins.
- `terminar` in EXEC or DONE is ignored.
- Timeout: the counter increments each cycle in WAIT_TIPO or WAIT_MONTO and clears on every accepted strobe and on entering WAIT_TIPO. When it reaches TIMEOUT_CYCLES−1 with no strobe that cycle, go to DONE.
- DONE: `fin`=1 for exactly one cycle with `sesion_activa`=1, then go to IDLE. `balance_out` holds its value in IDLE until the next `pin_ok`.
- Result pulses are mutually exclusive. At most one pulse per EXEC.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE. `balance_out`=0, all pulse outputs 0, `sesion_activa`=0, counters 0.
- Reset mid-session aborts the session with no `fin` and no writeback.
- `pin_ok` at cycle N: `sesion_activa`=1 and `balance_out`=`balance_in` at N+1.
- `monto_stb` at cycle M: EXEC at M+1. Result pulse and updated `balance_out` at M+2, state WAIT_TIPO.
- The earliest new `tipo_stb` is accepted at M+2.
- `terminar` at cycle T: `fin` at T+1, IDLE at T+2.
- Throughput: one transaction per 3 cycles minimum.

## Configuration
- `WITHDRAW_LIMIT_EN` defined: keep a MONTO_W+BAL_W-wide withdrawn accumulator.
  - A withdrawal with accumulator + monto > LIMITE_RETIRO that passes the funds check is rejected.
  - On rejection: pulse `limite_excedido`, balance and accumulator unchanged.
  - The funds check has priority, so `fondos_insuficientes` wins when both fail.
- `WITHDRAW_LIMIT_EN` undefined: no accumulator, `limite_excedido` tied to 0, `LIMITE_RETIRO` unused.

## Structure
- Shared package `atm_pkg`:
  - one-hot state constants ST_IDLE, ST_WAIT_TIPO, ST_WAIT_MONTO, ST_EXEC, ST_DONE;
  - TIPO_DEPOSITO = 1'b0, TIPO_RETIRO = 1'b1.
- Sub-module `atm_timeout_counter` (parameter TIMEOUT_CYCLES; ports clk, reset, clr, en, expirado). It is instantiated once.
- The FSM and the arithmetic stay in the top module.

## Test plan
- Balance 1000: `pin_ok` with `balance_in`=1000, deposit 250 → `deposito_ok` at M+2, `balance_out`=1250. Then `terminar` → `fin` with `balance_out`=1250.
- Overdraw: balance 100, withdrawal 101 → `fondos_insuficientes`, balance 100. Then withdrawal 100 → `entregar_dinero`, balance 0.
- Deposit overflow: BAL_W=16, balance 0xFFF0, deposit 0x0020 → `balance_out`=0xFFFF, `deposito_ok`=1.
- Timeout: TIMEOUT_CYCLES=8, session opened, no strobes → `fin` after 8 idle cycles in WAIT_TIPO.
- Abort cases:
  - `terminar` together with `monto_stb` → no result pulse, `fin` next cycle.
  - `reset`=0 mid-session → all outputs 0, no `fin`.
- With `WITHDRAW_LIMIT_EN`, LIMITE_RETIRO=500, balance 10000:
  - withdrawals 300 then 200 → both approved;
  - a further 1 → `limite_excedido`, balance 9500;
  - a new session resets the cap.
